// File: rtl/stopwatch_up_bcd_pkg.sv
// Shared definitions for the up-counting BCD stopwatch and its display path.
// Holds the FSM state encoding, the active-low 7-segment codes
// ({a,b,c,d,e,f,g,dp}, 0 = segment lit) and the active-low digit enables.
package stopwatch_up_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] SS_0 = 8'b00000011;
    localparam logic [7:0] SS_1 = 8'b10011111;
    localparam logic [7:0] SS_2 = 8'b00100101;
    localparam logic [7:0] SS_3 = 8'b00001101;
    localparam logic [7:0] SS_4 = 8'b10011001;
    localparam logic [7:0] SS_5 = 8'b01001001;
    localparam logic [7:0] SS_6 = 8'b01000001;
    localparam logic [7:0] SS_7 = 8'b00011111;
    localparam logic [7:0] SS_8 = 8'b00000001;
    localparam logic [7:0] SS_9 = 8'b00001001;
    localparam logic [7:0] SS_F = 8'b01110001;

    localparam logic [3:0] DIG0 = 4'b1110;  // ones digit enabled
    localparam logic [3:0] DIG1 = 4'b1101;  // tens digit enabled

endpackage

// File: rtl/stopwatch_up_bcd_bcd_to_seg.sv
// bcd_to_seg: combinational BCD digit to active-low 7-segment decoder.
// Non-decimal inputs (10..15) display 'F'.
//   i_bcd  in   4  BCD digit
//   o_seg  out  8  active-low segments {a,b,c,d,e,f,g,dp}
module bcd_to_seg
    import stopwatch_up_bcd_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SS_F;
        case (i_bcd)
            4'd0:    o_seg = SS_0;
            4'd1:    o_seg = SS_1;
            4'd2:    o_seg = SS_2;
            4'd3:    o_seg = SS_3;
            4'd4:    o_seg = SS_4;
            4'd5:    o_seg = SS_5;
            4'd6:    o_seg = SS_6;
            4'd7:    o_seg = SS_7;
            4'd8:    o_seg = SS_8;
            4'd9:    o_seg = SS_9;
            default: o_seg = SS_F;
        endcase
    end

endmodule

// File: rtl/stopwatch_up_bcd.sv
// stopwatch_up_bcd: two-digit BCD stopwatch counting up from 00 on each
// 1 Hz tick until it reaches {LIMIT_TENS,LIMIT_ONES}. Start/stop and
// lap/clear buttons drive a small FSM; a lap register can freeze the
// displayed value while the live count keeps running.
//   qclk     in   1   system clock (rising edge)
//   rst_n    in   1   asynchronous reset, active HIGH
//   tick     in   1   1 Hz single-cycle enable
//   btn_ss   in   1   start/stop button level (1 = pressed)
//   btn_lap  in   1   lap/clear button level (1 = pressed)
//   tens     out  4   live BCD tens digit
//   ones     out  4   live BCD ones digit
//   running  out  1   state is RUN
//   endled   out  15  all ones while in DONE
//   BCD_dsp  out  8   active-low segments {a,b,c,d,e,f,g,dp}
//   bit_dsp  out  4   active-low digit enable
//
// state | meaning
// IDLE  | count at 00, waiting for start
// RUN   | counting on tick, lap toggles display freeze
// PAUSE | count frozen; start resumes, lap clears
// DONE  | limit reached, count held, LEDs lit; lap clears
module stopwatch_up_bcd
    import stopwatch_up_bcd_pkg::*;
#(
    parameter int LIMIT_TENS = 5,
    parameter int LIMIT_ONES = 9,
    parameter int SCAN_W     = 20
) (
    input  logic        qclk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        btn_ss,
    input  logic        btn_lap,
    output logic [3:0]  tens,
    output logic [3:0]  ones,
    output logic        running,
    output logic [14:0] endled,
    output logic [7:0]  BCD_dsp,
    output logic [3:0]  bit_dsp
);

    localparam logic [3:0] LIM_T = 4'(LIMIT_TENS);
    localparam logic [3:0] LIM_O = 4'(LIMIT_ONES);

    state_t              r_state;
    logic [3:0]          r_tens;
    logic [3:0]          r_ones;
    logic                r_lap_hold;
    logic [3:0]          r_lap_tens;
    logic [3:0]          r_lap_ones;
    logic [SCAN_W-1:0]   r_scan;
    logic                r_ss_q;
    logic                r_lap_q;

    state_t              w_state_nx;
    logic [3:0]          w_tens_nx;
    logic [3:0]          w_ones_nx;
    logic                w_hold_nx;
    logic [3:0]          w_lap_tens_nx;
    logic [3:0]          w_lap_ones_nx;

    logic                w_ss_press;
    logic                w_lap_press;
    logic [3:0]          w_inc_tens;
    logic [3:0]          w_inc_ones;
    logic                w_at_limit;
    logic [3:0]          w_digit;

    // Start/stop wins over lap when both are pressed in the same cycle.
    assign w_ss_press  = btn_ss & ~r_ss_q;
    assign w_lap_press = btn_lap & ~r_lap_q & ~w_ss_press;

    assign w_inc_ones = (r_ones == 4'd9) ? 4'd0 : r_ones + 4'd1;
    assign w_inc_tens = (r_ones == 4'd9) ? r_tens + 4'd1 : r_tens;
    assign w_at_limit = (w_inc_tens == LIM_T) && (w_inc_ones == LIM_O);

    always_comb begin
        w_state_nx    = r_state;
        w_tens_nx     = r_tens;
        w_ones_nx     = r_ones;
        w_hold_nx     = r_lap_hold;
        w_lap_tens_nx = r_lap_tens;
        w_lap_ones_nx = r_lap_ones;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_press) w_state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (tick) begin
                    w_tens_nx = w_inc_tens;
                    w_ones_nx = w_inc_ones;
                end
                if (w_lap_press) begin
                    w_hold_nx = ~r_lap_hold;
                    // Freeze the value shown before this edge's increment.
                    if (!r_lap_hold) begin
                        w_lap_tens_nx = r_tens;
                        w_lap_ones_nx = r_ones;
                    end
                end
                // Reaching the limit outranks a simultaneous stop request.
                if (tick && w_at_limit) begin
                    w_state_nx = ST_DONE;
                    w_hold_nx  = 1'b0;
                end else if (w_ss_press) begin
                    w_state_nx = ST_PAUSE;
                    w_hold_nx  = 1'b0;
                end
            end
            ST_PAUSE: begin
                if (w_ss_press) begin
                    w_state_nx = ST_RUN;
                end else if (w_lap_press) begin
                    w_state_nx = ST_IDLE;
                    w_tens_nx  = 4'd0;
                    w_ones_nx  = 4'd0;
                    w_hold_nx  = 1'b0;
                end
            end
            ST_DONE: begin
                if (w_lap_press) begin
                    w_state_nx = ST_IDLE;
                    w_tens_nx  = 4'd0;
                    w_ones_nx  = 4'd0;
                    w_hold_nx  = 1'b0;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge qclk or posedge rst_n) begin
        if (rst_n) begin
            r_state    <= ST_IDLE;
            r_tens     <= 4'd0;
            r_ones     <= 4'd0;
            r_lap_hold <= 1'b0;
            r_lap_tens <= 4'd0;
            r_lap_ones <= 4'd0;
            r_scan     <= '0;
            // Button history comes out of reset as "already pressed" so a
            // button held through reset release does not count as a press.
            r_ss_q     <= 1'b1;
            r_lap_q    <= 1'b1;
        end else begin
            r_state    <= w_state_nx;
            r_tens     <= w_tens_nx;
            r_ones     <= w_ones_nx;
            r_lap_hold <= w_hold_nx;
            r_lap_tens <= w_lap_tens_nx;
            r_lap_ones <= w_lap_ones_nx;
            r_scan     <= r_scan + SCAN_W'(1);
            r_ss_q     <= btn_ss;
            r_lap_q    <= btn_lap;
        end
    end

    assign tens    = r_tens;
    assign ones    = r_ones;
    assign running = (r_state == ST_RUN);
    assign endled  = (r_state == ST_DONE) ? 15'h7FFF : 15'h0000;

    always_comb begin
        w_digit = r_lap_hold ? r_lap_ones : r_ones;
        if (r_scan[SCAN_W-1]) w_digit = r_lap_hold ? r_lap_tens : r_tens;
    end

    assign bit_dsp = r_scan[SCAN_W-1] ? DIG1 : DIG0;

    bcd_to_seg u_seg (
        .i_bcd (w_digit),
        .o_seg (BCD_dsp)
    );

endmodule

// File: tb/tb_stopwatch_up_bcd.sv
// Self-checking bench for stopwatch_up_bcd: directed scenarios with literal
// expectations, then randomized buttons/ticks/resets compared every cycle
// against an integer-level behavioural model.
module tb_stopwatch_up_bcd;

    localparam int SW = 4;

    logic        qclk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tick = 1'b0;
    logic        btn_ss = 1'b0;
    logic        btn_lap = 1'b0;
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic        running;
    logic [14:0] endled;
    logic [7:0]  BCD_dsp;
    logic [3:0]  bit_dsp;

    stopwatch_up_bcd #(.LIMIT_TENS(5), .LIMIT_ONES(9), .SCAN_W(SW)) dut (
        .qclk    (qclk),
        .rst_n   (rst_n),
        .tick    (tick),
        .btn_ss  (btn_ss),
        .btn_lap (btn_lap),
        .tens    (tens),
        .ones    (ones),
        .running (running),
        .endled  (endled),
        .BCD_dsp (BCD_dsp),
        .bit_dsp (bit_dsp)
    );

    always #5 qclk = ~qclk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [7:0] seg_tab [0:9];
    initial begin
        seg_tab[0] = 8'b00000011; seg_tab[1] = 8'b10011111;
        seg_tab[2] = 8'b00100101; seg_tab[3] = 8'b00001101;
        seg_tab[4] = 8'b10011001; seg_tab[5] = 8'b01001001;
        seg_tab[6] = 8'b01000001; seg_tab[7] = 8'b00011111;
        seg_tab[8] = 8'b00000001; seg_tab[9] = 8'b00001001;
    end

    // Behavioural model: count as a plain integer 0..59.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    localparam int LIMIT = 59;
    int m_st, m_cnt, m_lapv, m_scan;
    bit m_hold, m_pss, m_plap;

    always @(posedge qclk or posedge rst_n) begin
        if (rst_n) begin
            m_st = M_IDLE; m_cnt = 0; m_lapv = 0; m_scan = 0;
            m_hold = 0; m_pss = 1; m_plap = 1;
        end else begin
            bit ssp, lp;
            ssp = btn_ss && !m_pss;
            lp  = btn_lap && !m_plap && !ssp;
            m_pss = btn_ss; m_plap = btn_lap;
            m_scan = (m_scan + 1) % (1 << SW);
            case (m_st)
                M_IDLE: if (ssp) m_st = M_RUN;
                M_RUN: begin
                    int old;
                    old = m_cnt;
                    if (tick) m_cnt = m_cnt + 1;
                    if (lp) begin
                        if (!m_hold) m_lapv = old;
                        m_hold = !m_hold;
                    end
                    if (tick && m_cnt == LIMIT) begin
                        m_st = M_DONE; m_hold = 0;
                    end else if (ssp) begin
                        m_st = M_PAUSE; m_hold = 0;
                    end
                end
                M_PAUSE: begin
                    if (ssp) m_st = M_RUN;
                    else if (lp) begin m_st = M_IDLE; m_cnt = 0; m_hold = 0; end
                end
                default: if (lp) begin m_st = M_IDLE; m_cnt = 0; m_hold = 0; end
            endcase
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge qclk) begin
        if (chk_en) begin
            int shown, dig;
            bit msb;
            msb   = ((m_scan >> (SW - 1)) & 1) != 0;
            shown = m_hold ? m_lapv : m_cnt;
            dig   = msb ? shown / 10 : shown % 10;
            check("tens",    32'(tens),    32'(m_cnt / 10));
            check("ones",    32'(ones),    32'(m_cnt % 10));
            check("running", 32'(running), 32'(m_st == M_RUN));
            check("endled",  32'(endled),  (m_st == M_DONE) ? 32'h7FFF : 32'h0);
            check("bit_dsp", 32'(bit_dsp), msb ? 32'hD : 32'hE);
            check("BCD_dsp", 32'(BCD_dsp), 32'(seg_tab[dig]));
        end
    end

    task automatic step(input bit t, input bit s, input bit l);
        tick = t; btn_ss = s; btn_lap = l;
        @(posedge qclk);
        #1;
    endtask

    task automatic press_ss();
        step(0, 1, 0); step(0, 0, 0);
    endtask

    task automatic press_lap();
        step(0, 0, 1); step(0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0);
        step(0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        step(0, 0, 0);
        rst_n = 1'b0;
        step(0, 0, 0);
    endtask

    task automatic check_val(input string nm, input int exp);
        check(nm, 32'(tens) * 10 + 32'(ones), 32'(exp));
    endtask

    // Scan through both digit phases, checking literal segment patterns.
    task automatic check_mux(input string nm, input logic [7:0] seg_ones, input logic [7:0] seg_tens);
        for (int i = 0; i < (1 << SW); i++) begin
            step(0, 0, 0);
            if (((m_scan >> (SW - 1)) & 1) != 0) begin
                check({nm, "_dig1"}, 32'(bit_dsp), 32'hD);
                check({nm, "_seg1"}, 32'(BCD_dsp), 32'(seg_tens));
            end else begin
                check({nm, "_dig0"}, 32'(bit_dsp), 32'hE);
                check({nm, "_seg0"}, 32'(BCD_dsp), 32'(seg_ones));
            end
        end
    endtask

    initial begin
        step(0, 0, 0);
        step(0, 0, 0);
        rst_n = 1'b0;
        step(0, 0, 0);
        chk_en = 1'b1;
        check("rst_val", 32'(tens) * 10 + 32'(ones), 32'd0);
        check("rst_seg", 32'(BCD_dsp), 32'h03);

        // Start, 12 ticks, digit mux.
        press_ss();
        ticks(12);
        check_val("t12_val", 12);
        check("t12_run", 32'(running), 32'd1);
        check("t12_led", 32'(endled), 32'd0);
        check_mux("t12", 8'b00100101, 8'b10011111);

        // BCD carry and limit.
        do_reset();
        press_ss();
        ticks(8);
        check_val("c08", 8);
        ticks(1);
        check_val("c09", 9);
        ticks(1);
        check_val("c10", 10);
        ticks(49);
        check_val("lim59", 59);
        check("lim_led", 32'(endled), 32'h7FFF);
        check("lim_run", 32'(running), 32'd0);
        ticks(4);
        check_val("hold59", 59);
        press_ss();
        check("done_ss", 32'(running), 32'd0);
        press_lap();
        check_val("clr00", 0);
        check("clr_led", 32'(endled), 32'd0);

        // Tick and stop in the same cycle.
        do_reset();
        press_ss();
        ticks(7);
        step(1, 1, 0);
        step(0, 0, 0);
        check_val("tss08", 8);
        check("tss_run", 32'(running), 32'd0);
        ticks(5);
        check_val("pause08", 8);
        press_ss();
        check("resume_run", 32'(running), 32'd1);
        ticks(1);
        check_val("resume09", 9);

        // Lap freeze.
        do_reset();
        press_ss();
        ticks(15);
        press_lap();
        ticks(3);
        check_val("lap_live18", 18);
        check_mux("lap15", 8'b01001001, 8'b10011111);
        press_lap();
        check_mux("lap18", 8'b00000001, 8'b10011111);

        // Asynchronous reset mid-cycle with start held through release.
        do_reset();
        press_ss();
        ticks(33);
        #2;
        rst_n = 1'b1;
        btn_ss = 1'b1;
        #1;
        check_val("arst_val", 0);
        check("arst_run", 32'(running), 32'd0);
        check("arst_dig", 32'(bit_dsp), 32'hE);
        step(0, 1, 0);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        check("held_ss", 32'(running), 32'd0);
        step(0, 0, 0);
        press_ss();
        check("repress_run", 32'(running), 32'd1);

        // Start and lap together in PAUSE.
        do_reset();
        press_ss();
        ticks(4);
        press_ss();
        step(0, 1, 1);
        step(0, 0, 0);
        check("sslap_run", 32'(running), 32'd1);
        check_val("sslap04", 4);

        // Randomized traffic.
        do_reset();
        begin
            bit s, l;
            s = 0; l = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(59) == 0) s = !s;
                if ($urandom_range(24) == 0) l = !l;
                if ($urandom_range(599) == 0) begin
                    rst_n = 1'b1;
                    step($urandom_range(3) != 0, s, l);
                    rst_n = 1'b0;
                end else begin
                    step($urandom_range(3) != 0, s, l);
                end
            end
        end
        step(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
